// File: rtl/window_match_pkg.sv
`default_nettype none
// ============================================================================
// Module   : window_match_pkg
// Purpose  : Shared types and widths for the window match controller.
// Revision : 1.0 - initial release
// ============================================================================
package window_match_pkg;

    localparam int c_CFG_W         = 4;
    localparam int c_CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/window_sampler.sv
`default_nettype none
// ============================================================================
// Module   : window_sampler
// Purpose  : Sample index, hit counter and end-of-window match detection.
// Revision : 1.0 - initial release
// ============================================================================
module window_sampler
    import window_match_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_enable,
    input  logic               i_w,
    input  logic [c_CFG_W-1:0] i_len,
    input  logic [c_CFG_W-1:0] i_target,
    output logic               o_last,
    output logic               o_matched
);

    logic [c_CFG_W-1:0] r_idx;
    logic [c_CFG_W-1:0] r_hits;
    logic [c_CFG_W-1:0] w_last_idx;
    logic [c_CFG_W:0]   w_total;
    logic               w_last;

    // A zero length behaves as a one-sample window
    assign w_last_idx = (i_len == '0) ? '0 : i_len - c_CFG_W'(1);
    assign w_last     = i_enable && (r_idx == w_last_idx);
    // One extra bit keeps a full window of ones from wrapping
    assign w_total    = {1'b0, r_hits} + {{c_CFG_W{1'b0}}, i_w};

    assign o_last    = w_last;
    assign o_matched = (w_total == {1'b0, i_target});

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_idx  <= '0;
            r_hits <= '0;
        end else if (i_enable) begin
            if (w_last) begin
                r_idx  <= '0;
                r_hits <= '0;
            end else begin
                r_idx  <= r_idx + c_CFG_W'(1);
                r_hits <= r_hits + {{(c_CFG_W-1){1'b0}}, i_w};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/window_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : window_match_ctrl
// Purpose  : Run FSM counting w=1 samples per window and matching a target.
// Revision : 1.0 - initial release
// ============================================================================
module window_match_ctrl
    import window_match_pkg::*;
#(
    parameter int CNT_W = c_CNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [c_CFG_W-1:0] cfg_win_len,
    input  logic [c_CFG_W-1:0] cfg_target,
    input  logic [CNT_W-1:0]   cfg_num_win,
    input  logic               w,
    output logic               busy,
    output logic               result_valid,
    output logic               z,
    output logic               done,
    output logic [CNT_W-1:0]   win_count,
    output logic [CNT_W-1:0]   match_count
);

    state_t             r_state;
    logic [c_CFG_W-1:0] r_len;
    logic [c_CFG_W-1:0] r_target;
    logic [CNT_W-1:0]   r_num_win;
    logic               r_busy;
    logic               r_result_valid;
    logic               r_z;
    logic               r_done;
    logic [CNT_W-1:0]   r_win_count;
    logic [CNT_W-1:0]   r_match_count;

    logic               w_accept;
    logic               w_enable;
    logic               w_last;
    logic               w_matched;
    logic [CNT_W-1:0]   w_win_next;

    assign w_accept   = (r_state == IDLE) && start && !abort;
    // An aborting cycle takes no sample so the partial window never completes
    assign w_enable   = (r_state == RUN) && !abort;
    assign w_win_next = r_win_count + CNT_W'(1);

    window_sampler u_sampler (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_accept),
        .i_enable  (w_enable),
        .i_w       (w),
        .i_len     (r_len),
        .i_target  (r_target),
        .o_last    (w_last),
        .o_matched (w_matched)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_len          <= '0;
            r_target       <= '0;
            r_num_win      <= '0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_z            <= 1'b0;
            r_done         <= 1'b0;
            r_win_count    <= '0;
            r_match_count  <= '0;
        end else begin
            r_result_valid <= 1'b0;
            r_z            <= 1'b0;
            r_done         <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_len         <= cfg_win_len;
                        r_target      <= cfg_target;
                        r_num_win     <= cfg_num_win;
                        r_win_count   <= '0;
                        r_match_count <= '0;
                        r_busy        <= 1'b1;
                        r_state       <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_last) begin
                        r_result_valid <= 1'b1;
                        r_z            <= w_matched;
                        r_win_count    <= w_win_next;
                        if (w_matched && (r_match_count != '1)) begin
                            r_match_count <= r_match_count + CNT_W'(1);
                        end
                        if ((r_num_win != '0) && (w_win_next == r_num_win)) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign result_valid = r_result_valid;
    assign z            = r_z;
    assign done         = r_done;
    assign win_count    = r_win_count;
    assign match_count  = r_match_count;

endmodule
`default_nettype wire

// File: tb/tb_window_match_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_match_ctrl
// Purpose  : Directed and randomized self-checking bench for window_match_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_window_match_ctrl;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             w = 1'b0;
    logic [3:0]       cfg_win_len = '0;
    logic [3:0]       cfg_target = '0;
    logic [CNT_W-1:0] cfg_num_win = '0;
    logic             busy;
    logic             result_valid;
    logic             z;
    logic             done;
    logic [CNT_W-1:0] win_count;
    logic [CNT_W-1:0] match_count;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    window_match_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .cfg_win_len  (cfg_win_len),
        .cfg_target   (cfg_target),
        .cfg_num_win  (cfg_num_win),
        .w            (w),
        .busy         (busy),
        .result_valid (result_valid),
        .z            (z),
        .done         (done),
        .win_count    (win_count),
        .match_count  (match_count)
    );

    // Reference model: 0 idle, 1 running, 2 finished; window held as a sample list
    int m_mode = 0;
    int m_len, m_target, m_num, m_ones;
    int m_wc = 0;
    int m_mc = 0;
    bit m_samp[$];
    bit e_busy = 0, e_rv = 0, e_z = 0, e_done = 0;

    always @(posedge clk) begin
        e_rv = 0; e_z = 0; e_done = 0;
        if (reset) begin
            m_mode = 0; m_wc = 0; m_mc = 0; e_busy = 0;
            m_samp.delete();
        end else if (m_mode == 0) begin
            if (start && !abort) begin
                m_len    = (cfg_win_len == 0) ? 1 : int'(cfg_win_len);
                m_target = int'(cfg_target);
                m_num    = int'(cfg_num_win);
                m_wc = 0; m_mc = 0; m_mode = 1; e_busy = 1;
                m_samp.delete();
            end
        end else if (m_mode == 1) begin
            if (abort) begin
                m_mode = 0; e_busy = 0;
            end else begin
                m_samp.push_back(w);
                if (m_samp.size() == m_len) begin
                    m_ones = 0;
                    foreach (m_samp[i]) m_ones += int'(m_samp[i]);
                    e_rv = 1;
                    e_z  = (m_ones == m_target);
                    m_wc = (m_wc + 1) % (1 << CNT_W);
                    if (e_z && m_mc < (1 << CNT_W) - 1) m_mc++;
                    m_samp.delete();
                    if (m_num != 0 && m_wc == m_num) begin
                        m_mode = 2; e_done = 1; e_busy = 0;
                    end
                end
            end
        end else begin
            m_mode = 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", busy, e_busy);
            chk("result_valid", result_valid, e_rv);
            chk("z", z, e_z);
            chk("done", done, e_done);
            chk("win_count", win_count, m_wc);
            chk("match_count", match_count, m_mc);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic begin_run(input int len, input int tgt, input int num);
        cfg_win_len = 4'(len);
        cfg_target  = 4'(tgt);
        cfg_num_win = CNT_W'(num);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic sample(input bit b);
        w = b;
        step();
    endtask

    int pulses, dones;

    initial begin
        step(); step();
        reset = 1'b0;
        cmp_en = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_wc", win_count, 0);

        // single window, done coincides with result
        begin_run(3, 2, 1);
        chk("t1_busy", busy, 1);
        sample(1); sample(1); sample(0);
        chk("t1_rv", result_valid, 1);
        chk("t1_z", z, 1);
        chk("t1_done", done, 1);
        chk("t1_wc", win_count, 1);
        chk("t1_mc", match_count, 1);
        step();
        chk("t1_busy_after", busy, 0);
        step(); step();
        chk("t1_wc_hold", win_count, 1);

        // two windows
        begin_run(3, 2, 2);
        sample(1); sample(1); sample(1);
        chk("t2_rv1", result_valid, 1);
        chk("t2_z1", z, 0);
        chk("t2_done1", done, 0);
        sample(0);
        chk("t2_gap_rv", result_valid, 0);
        sample(1); sample(1);
        chk("t2_rv2", result_valid, 1);
        chk("t2_z2", z, 1);
        chk("t2_done2", done, 1);
        chk("t2_mc", match_count, 1);
        chk("t2_wc", win_count, 2);
        step(); step();

        // continuous run, then abort mid-window
        begin_run(4, 4, 0);
        pulses = 0; dones = 0;
        w = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (result_valid) begin
                pulses++;
                chk("t3_z", z, 1);
            end
            if (done) dones++;
        end
        chk("t3_pulses", pulses, 5);
        chk("t3_dones", dones, 0);
        chk("t3_busy", busy, 1);
        step(); step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t3_abort_busy", busy, 0);
        chk("t3_abort_rv", result_valid, 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (result_valid) pulses++;
        end
        chk("t3_post_abort", pulses, 0);

        // reset mid-window, then a fresh window
        begin_run(3, 1, 0);
        sample(1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_wc", win_count, 0);
        begin_run(3, 1, 1);
        sample(1); sample(0); sample(0);
        chk("t4_rv", result_valid, 1);
        chk("t4_z", z, 1);
        chk("t4_done", done, 1);
        step(); step();

        // zero length acts as one; target change mid-run ignored
        begin_run(0, 1, 0);
        sample(1);
        chk("t5_z1", z, 1);
        cfg_target = 4'd0;
        sample(0);
        chk("t5_rv2", result_valid, 1);
        chk("t5_z2", z, 0);
        sample(1);
        chk("t5_z3", z, 1);
        abort = 1'b1;
        step();
        // abort beats start in IDLE
        start = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        step();
        chk("t6_abort_wins", busy, 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            w           = 1'($urandom_range(0, 1));
            cfg_win_len = 4'($urandom_range(0, 5));
            cfg_target  = 4'($urandom_range(0, 6));
            cfg_num_win = CNT_W'($urandom_range(0, 5));
            start       = ($urandom_range(0, 3) == 0);
            abort       = ($urandom_range(0, 59) == 0);
            reset       = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/window_match_ctrl.md
WINDOW_MATCH_CTRL -- requirements
Module: window_match_ctrl

Interface
REQ-001 Parameter: CNT_W, default 8, width of window-count and match-count fields.
REQ-002 Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a measurement run; honoured only in IDLE.
- abort  in  1  terminate the run at once; no result for the partial window.
- cfg_win_len  in  4  window length in samples; 0 treated as 1.
- cfg_target  in  4  required count of w=1 samples per window.
- cfg_num_win  in  CNT_W  number of windows per run; 0 means continuous.
- w  in  1  sampled input.
- busy  out  1  high in RUN.
- result_valid  out  1  one-cycle pulse per completed window.
- z  out  1  window matched; qualified by result_valid, otherwise 0.
- done  out  1  one-cycle pulse when a finite run completes.
- win_count  out  CNT_W  windows completed this run.
- match_count  out  CNT_W  matching windows this run, saturating.

Function
REQ-003 States SHALL be IDLE, RUN and DONE.
REQ-004 IDLE with start=1 and abort=0 SHALL:
- latch cfg_win_len, cfg_target and cfg_num_win;
- clear win_count, match_count, the sample index and the hit count;
- go to RUN.
REQ-005 The first w sample SHALL be taken in the first RUN cycle, one cycle after start.
REQ-006 Every RUN cycle SHALL sample w once. The index counts 0..len-1; the hit count increments when w=1.
REQ-007 At index len-1, total = hits + w. The next cycle SHALL drive:
- result_valid=1;
- z = (total == latched target);
- win_count += 1;
- match_count += 1 if matched, saturating at all-ones.
REQ-008 Windows SHALL be back-to-back: the cycle after the last sample of a window takes sample 0 of the next window, with index and hits restarted.
REQ-009 If cfg_num_win != 0 and the completed window makes win_count equal cfg_num_win:
- the FSM SHALL go to DONE;
- done=1 and result_valid=1 SHALL coincide for that final window.
REQ-010 DONE SHALL last one cycle, then return to IDLE. start in DONE is ignored.
REQ-011 With cfg_num_win=0, RUN SHALL continue until abort or reset. win_count wraps modulo 2^CNT_W.
REQ-012 abort=1 in RUN SHALL go to IDLE next cycle with no result_valid and no done. abort in IDLE beats start.
REQ-013 start in RUN or DONE SHALL be ignored.
REQ-014 Configuration changes during RUN SHALL have no effect; the latched values govern.
REQ-015 cfg_target > window length SHALL never match. cfg_target = 0 matches only all-zero windows.
REQ-016 win_count and match_count SHALL hold their values in IDLE until the next accepted start.
REQ-017 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-018 reset=1 at a clock edge SHALL force IDLE. This overrides start, abort and a mid-window run.
REQ-019 Reset values: busy=0, result_valid=0, z=0, done=0, win_count=0, match_count=0; index, hits and latched config cleared.
REQ-020 The first start SHALL be accepted on the cycle after reset deasserts.

Structure
REQ-021 Shared package window_match_pkg SHALL hold:
- the state enum (IDLE, RUN, DONE);
- the 4-bit length/target width constant;
- the CNT_W default.
REQ-022 Sub-module window_sampler SHALL hold the sample index, the hit counter and the end-of-window/total logic. window_match_ctrl holds the FSM and the run counters.

Verification
REQ-023 len=3, target=2, num_win=1, start, then w=1,1,0 -> one cycle after the third sample: result_valid=1, z=1, done=1, win_count=1, match_count=1.
REQ-024 len=3, target=2, num_win=2, w=1,1,1,0,1,1 -> two result_valid pulses 3 cycles apart, z=0 then z=1; done with the second pulse; match_count=1.
REQ-025 len=4, num_win=0, w held 1 for 20 cycles, target=4 -> result_valid every 4 cycles with z=1, no done, busy stays 1; abort mid-window -> IDLE next cycle, no further result_valid.
REQ-026 Reset asserted at index 1 of a window -> next cycle all outputs 0 and state IDLE; a later start begins a fresh window.
REQ-027 cfg_win_len=0 with target=1 and w=1,0,1 -> three 1-sample windows, z=1,0,1. Changing cfg_target mid-run alters no result.
